// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception/interrupt arbiter driving CP0's exception record and the fetch redirect.
// Optional macro EXC_TIMER_INT_EN: Cause.TI is ORed into interrupt line IP7.

typedef struct packed {
  logic        exception_en;
  logic [31:0] EPC;
  logic        BD;
  logic [31:0] BadVAddr;
  logic [4:0]  ExeCode;
} cp0_reg_input_t;

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           commit_valid,
  input  logic [31:0]    commit_pc,
  input  logic           commit_bd,
  input  logic [6:0]     commit_exc,
  input  logic [31:0]    commit_vaddr,
  input  logic           commit_eret,
  input  logic [31:0]    cp0_status,
  input  logic [31:0]    cp0_cause,
  input  logic [31:0]    cp0_epc,
  input  logic [5:0]     ext_int,
  output cp0_reg_input_t cp0_reg_input,
  output logic           eret,
  output logic           flush,
  output logic           redir_valid,
  output logic [31:0]    redir_pc,
  input  logic           redir_ready
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  logic [0:0]  state;
  logic [5:0]  ext_meta;
  logic [5:0]  ext_sync;
  logic        int_pending;
  logic [7:0]  ip_eff;
  logic        exc_hit;
  logic [4:0]  exe_code;
  logic [31:0] bad_vaddr;
  logic        accept_slot;
  logic        unused_cp0_bits;

  assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

  always_comb begin
    ip_eff = {cp0_cause[15:10] | ext_sync, cp0_cause[9:8]};
`ifdef EXC_TIMER_INT_EN
    ip_eff[7] = ip_eff[7] | cp0_cause[30];
`else
    ip_eff[7] = ip_eff[7];
`endif
  end

  // External lines are asynchronous: two flops before they may influence the pending flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ext_meta    <= 6'd0;
      ext_sync    <= 6'd0;
      int_pending <= 1'b0;
    end else begin
      ext_meta    <= ext_int;
      ext_sync    <= ext_meta;
      int_pending <= cp0_status[0] & ~cp0_status[1] & (|(cp0_status[15:8] & ip_eff));
    end
  end

  always_comb begin
    exc_hit   = 1'b1;
    exe_code  = 5'h00;
    bad_vaddr = 32'd0;
    if (int_pending) begin
      exe_code = 5'h00;
    end else if (commit_exc[6]) begin
      exe_code  = 5'h04;
      bad_vaddr = commit_pc;
    end else if (commit_exc[5]) begin
      exe_code = 5'h0A;
    end else if (commit_exc[4]) begin
      exe_code = 5'h0C;
    end else if (commit_exc[3]) begin
      exe_code = 5'h08;
    end else if (commit_exc[2]) begin
      exe_code = 5'h09;
    end else if (commit_exc[1]) begin
      exe_code  = 5'h04;
      bad_vaddr = commit_vaddr;
    end else if (commit_exc[0]) begin
      exe_code  = 5'h05;
      bad_vaddr = commit_vaddr;
    end else begin
      exc_hit = 1'b0;
    end
  end

  // Outputs are held low while reset is asserted, regardless of the commit inputs.
  assign accept_slot = resetn && (state == IDLE) && commit_valid;
  assign redir_valid = (state == REDIRECT);

  always_comb begin
    cp0_reg_input = '0;
    eret          = 1'b0;
    flush         = 1'b0;
    if (accept_slot) begin
      if (exc_hit) begin
        cp0_reg_input.exception_en = 1'b1;
        cp0_reg_input.EPC          = commit_bd ? (commit_pc - 32'd4) : commit_pc;
        cp0_reg_input.BD           = commit_bd;
        cp0_reg_input.BadVAddr     = bad_vaddr;
        cp0_reg_input.ExeCode      = exe_code;
        flush                      = 1'b1;
      end else if (commit_eret) begin
        eret  = 1'b1;
        flush = 1'b1;
      end
    end else if (state == REDIRECT) begin
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      redir_pc <= 32'd0;
    end else if (state == IDLE) begin
      if (accept_slot && exc_hit) begin
        redir_pc <= EXC_VECTOR;
        state    <= REDIRECT;
      end else if (accept_slot && commit_eret) begin
        redir_pc <= cp0_epc;
        state    <= REDIRECT;
      end
    end else if (redir_ready) begin
      state <= IDLE;
    end
  end

endmodule
